// File: rtl/fault_input_filter_if.sv
// fault_input_filter_if: raw fault lines in, debounced lines and first-fault diagnostics out.
interface fault_input_filter_if;
    logic [4:0] MOT_ERR;
    logic [2:0] FAIL_SENSn;
    logic       CLR_FIRST;
    logic [4:0] MOT_ERR_F;
    logic [2:0] FAIL_SENSn_F;
    logic       FAULT_ANY;
    logic       FIRST_VALID;
    logic [2:0] FIRST_FAULT;
    modport master (
        output MOT_ERR, FAIL_SENSn, CLR_FIRST,
        input  MOT_ERR_F, FAIL_SENSn_F, FAULT_ANY, FIRST_VALID, FIRST_FAULT
    );
    modport slave (
        input  MOT_ERR, FAIL_SENSn, CLR_FIRST,
        output MOT_ERR_F, FAIL_SENSn_F, FAULT_ANY, FIRST_VALID, FIRST_FAULT
    );
endinterface

// File: rtl/fault_input_filter.sv
// fault_input_filter: synchronise and debounce 8 fault lines, latch the first channel to fault.
module fault_input_filter #(
    parameter int DEBOUNCE = 16,
    parameter int CNT_W    = 8
) (
    input logic CLK,
    input logic RST,
    fault_input_filter_if.slave bus
);
    // No-fault level per channel: MOT_ERR active-high, FAIL_SENSn active-low.
    localparam logic [7:0] IDLE = 8'he0;
    logic [7:0]       raw, sync1, s, f, flt;
    logic [CNT_W-1:0] cnt [8];
    logic             valid;
    logic [2:0]       first, lowest;
    assign raw = {bus.FAIL_SENSn, bus.MOT_ERR};
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= IDLE;
            s     <= IDLE;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end
    always_ff @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (RST || s[i] == f[i]) begin
                f[i]   <= RST ? IDLE[i] : f[i];
                cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
                f[i]   <= s[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end
    assign flt = f ^ IDLE;
    always_comb begin
        lowest = '0;
        for (int i = 7; i >= 0; i--) lowest = flt[i] ? 3'(i) : lowest;
    end
    always_ff @(posedge CLK) begin
        if (RST || bus.CLR_FIRST) begin
            valid <= 1'b0;
            first <= '0;
        end else if (!valid && |flt) begin
            valid <= 1'b1;
            first <= lowest;
        end
    end
    assign bus.MOT_ERR_F    = f[4:0];
    assign bus.FAIL_SENSn_F = f[7:5];
    assign bus.FAULT_ANY    = |flt;
    assign bus.FIRST_VALID  = valid;
    assign bus.FIRST_FAULT  = first;
endmodule

// File: tb/tb_fault_input_filter.sv
// tb_fault_input_filter: directed literal checks plus randomized run against a window-based reference model.
module tb_fault_input_filter;
    localparam int D = 4;
    localparam logic [7:0] IDLE = 8'he0;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   failures = 0;
    logic cmp_en = 1'b0;
    fault_input_filter_if bus();
    fault_input_filter #(.DEBOUNCE(D), .CNT_W(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    // Reference: a channel's filtered level flips once the last D synchronised samples all disagree with it.
    logic [7:0] m_sync1, m_s, m_f, m_flt;
    logic       m_valid;
    logic [2:0] m_first;
    logic [7:0] hist[$];
    logic       all_diff;
    function automatic logic [2:0] lowest_of(input logic [7:0] v);
        lowest_of = '0;
        for (int i = 7; i >= 0; i--) if (v[i]) lowest_of = 3'(i);
    endfunction
    always @(posedge CLK) begin
        if (RST) begin
            m_sync1 = IDLE;
            m_s = IDLE;
            m_f = IDLE;
            hist.delete();
            m_valid = 1'b0;
            m_first = '0;
        end else begin
            m_flt = m_f ^ IDLE;
            if (bus.CLR_FIRST) begin
                m_valid = 1'b0;
                m_first = '0;
            end else if (!m_valid && m_flt != 0) begin
                m_valid = 1'b1;
                m_first = lowest_of(m_flt);
            end
            hist.push_back(m_s);
            if (hist.size() > D) void'(hist.pop_front());
            if (hist.size() == D) begin
                for (int c = 0; c < 8; c++) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][c] == m_f[c]) all_diff = 1'b0;
                    if (all_diff) m_f[c] = ~m_f[c];
                end
            end
            m_s = m_sync1;
            m_sync1 = {bus.FAIL_SENSn, bus.MOT_ERR};
        end
    end
    logic [14:0] act_v, exp_v;
    always @(posedge CLK) begin
        #1;
        if (cmp_en) begin
            act_v = {bus.MOT_ERR_F, bus.FAIL_SENSn_F, bus.FAULT_ANY, bus.FIRST_VALID, bus.FIRST_FAULT};
            exp_v = {m_f[4:0], m_f[7:5], |(m_f ^ IDLE), m_valid, m_first};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask
    task automatic do_reset();
        bus.MOT_ERR = 5'h00;
        bus.FAIL_SENSn = 3'b111;
        bus.CLR_FIRST = 1'b0;
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
    endtask
    int cnt_z;
    logic [7:0] r;
    initial begin
        bus.CLR_FIRST = 1'b0;
        bus.MOT_ERR = 5'h1f;
        bus.FAIL_SENSn = 3'b000;
        RST = 1'b1;
        tick(3);
        cmp_en = 1'b1;
        RST = 1'b0;
        chk("rst_mot", bus.MOT_ERR_F, 5'h00);
        chk("rst_fs", bus.FAIL_SENSn_F, 3'b111);
        chk("rst_any", bus.FAULT_ANY, 0);
        chk("rst_valid", bus.FIRST_VALID, 0);
        tick(D + 1);
        chk("requal_early", bus.MOT_ERR_F, 5'h00);
        tick(1);
        chk("requal_mot", bus.MOT_ERR_F, 5'h1f);
        chk("requal_fs", bus.FAIL_SENSn_F, 3'b000);
        tick(1);
        chk("requal_first", {bus.FIRST_VALID, bus.FIRST_FAULT}, 4'b1000);
        do_reset();
        bus.MOT_ERR = 5'b00100;
        tick(5);
        chk("clean_e5", bus.MOT_ERR_F, 5'b00000);
        tick(1);
        chk("clean_e6", bus.MOT_ERR_F, 5'b00100);
        chk("clean_any", bus.FAULT_ANY, 1);
        chk("clean_v6", bus.FIRST_VALID, 0);
        tick(1);
        chk("clean_first", {bus.FIRST_VALID, bus.FIRST_FAULT}, 4'b1010);
        do_reset();
        bus.FAIL_SENSn = 3'b101;
        cnt_z = 0;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (i == 2) bus.FAIL_SENSn = 3'b111;
            if (bus.FAIL_SENSn_F != 3'b111) cnt_z++;
        end
        chk("glitch3", cnt_z, 0);
        chk("glitch3_valid", bus.FIRST_VALID, 0);
        bus.FAIL_SENSn = 3'b101;
        cnt_z = 0;
        for (int i = 0; i < 18; i++) begin
            tick(1);
            if (i == 3) bus.FAIL_SENSn = 3'b111;
            if (!bus.FAIL_SENSn_F[1]) cnt_z++;
        end
        chk("pulse4_len", cnt_z, 4);
        do_reset();
        bus.MOT_ERR = 5'b01000;
        bus.FAIL_SENSn = 3'b110;
        tick(8);
        chk("simul_first", {bus.FIRST_VALID, bus.FIRST_FAULT}, 4'b1011);
        bus.MOT_ERR = 5'b01001;
        tick(8);
        chk("later_mot", bus.MOT_ERR_F, 5'b01001);
        chk("later_first", {bus.FIRST_VALID, bus.FIRST_FAULT}, 4'b1011);
        do_reset();
        bus.MOT_ERR = 5'b10000;
        tick(8);
        chk("clr_pre", {bus.FIRST_VALID, bus.FIRST_FAULT}, 4'b1100);
        bus.CLR_FIRST = 1'b1;
        tick(1);
        bus.CLR_FIRST = 1'b0;
        chk("clr_gap", bus.FIRST_VALID, 0);
        tick(1);
        chk("clr_recap", {bus.FIRST_VALID, bus.FIRST_FAULT}, 4'b1100);
        bus.MOT_ERR = 5'b00000;
        tick(8);
        chk("clr_drop_any", bus.FAULT_ANY, 0);
        bus.CLR_FIRST = 1'b1;
        tick(1);
        bus.CLR_FIRST = 1'b0;
        tick(2);
        chk("clr_idle", bus.FIRST_VALID, 0);
        do_reset();
        bus.MOT_ERR = 5'b00010;
        tick(4);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("midrst_out", bus.MOT_ERR_F, 5'b00000);
        tick(5);
        chk("midrst_e5", bus.MOT_ERR_F, 5'b00000);
        tick(1);
        chk("midrst_e6", bus.MOT_ERR_F, 5'b00010);
        do_reset();
        r = IDLE;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
            bus.MOT_ERR = r[4:0];
            bus.FAIL_SENSn = r[7:5];
            bus.CLR_FIRST = ($urandom_range(0, 19) == 0);
            RST = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        RST = 1'b0;
        bus.CLR_FIRST = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
